cve2_irq_ctrl: RTL and testbench

Interrupt front-end that sits directly upstream of the core's controller and CSR interrupt-pending logic. It synchronises raw asynchronous interrupt sources and applies per-source level or edge capture. It holds edge events pending until the core acknowledges them, and presents the result as an irqs_t bundle plus NMI. A registered-state priority encoder also reports the winning interrupt ID, using mcause[4:0] encoding.

---
 rtl/cve2_irq_ctrl_pkg.sv | 45 ++++
 rtl/cve2_irq_ctrl_if.sv | 24 ++
 rtl/cve2_irq_sync.sv | 29 ++
 rtl/cve2_irq_ctrl.sv | 64 ++++++
 tb/tb_cve2_irq_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cve2_irq_ctrl_pkg.sv
// Shared interrupt types and ID constants for the interrupt front-end.
// IDs match the low five bits of mcause for each source.
package cve2_irq_ctrl_pkg;

  typedef struct packed {
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [14:0] irq_fast;
  } irqs_t;

  localparam int unsigned IRQ_NUM_SRC  = 18;
  localparam int unsigned IRQ_NUM_FAST = 15;

  localparam logic [4:0] IRQ_ID_SW        = 5'd3;
  localparam logic [4:0] IRQ_ID_TIMER     = 5'd7;
  localparam logic [4:0] IRQ_ID_EXT       = 5'd11;
  localparam logic [4:0] IRQ_ID_FAST_BASE = 5'd16;
  localparam logic [4:0] IRQ_ID_NM        = 5'd31;

  // Maps an irqs_t bit index to its mcause ID.
  function automatic logic [4:0] irq_src_id(int unsigned idx);
    logic [4:0] id;
    if (idx == 17)      id = IRQ_ID_SW;
    else if (idx == 16) id = IRQ_ID_TIMER;
    else if (idx == 15) id = IRQ_ID_EXT;
    else                id = IRQ_ID_FAST_BASE + 5'(idx);
    return id;
  endfunction

  // Later assignments win, so the lowest-priority sources are tested first.
  function automatic logic [4:0] irq_prio_id(irqs_t irqs, logic nm);
    logic [4:0] id;
    id = '0;
    if (irqs.irq_timer)    id = IRQ_ID_TIMER;
    if (irqs.irq_software) id = IRQ_ID_SW;
    if (irqs.irq_external) id = IRQ_ID_EXT;
    for (int i = IRQ_NUM_FAST - 1; i >= 0; i--) begin
      if (irqs.irq_fast[4'(i)]) id = IRQ_ID_FAST_BASE + 5'(i);
    end
    if (nm) id = IRQ_ID_NM;
    return id;
  endfunction

endpackage

// File: rtl/cve2_irq_ctrl_if.sv
// Source, acknowledge and result signals between the core and the interrupt front-end.
interface cve2_irq_ctrl_if;
  import cve2_irq_ctrl_pkg::*;

  logic [IRQ_NUM_SRC-1:0] irq_src_i;
  logic                   irq_nm_src_i;
  logic                   ack_valid_i;
  logic [4:0]             ack_id_i;
  irqs_t                  irqs_o;
  logic                   irq_nm_o;
  logic                   irq_pending_o;
  logic [4:0]             irq_id_o;

  modport master (
    output irq_src_i, irq_nm_src_i, ack_valid_i, ack_id_i,
    input  irqs_o, irq_nm_o, irq_pending_o, irq_id_o
  );

  modport slave (
    input  irq_src_i, irq_nm_src_i, ack_valid_i, ack_id_i,
    output irqs_o, irq_nm_o, irq_pending_o, irq_id_o
  );

endinterface

// File: rtl/cve2_irq_sync.sv
// Width x SyncStages flop-chain synchroniser with synchronous active-low reset.
module cve2_irq_sync #(
  parameter int unsigned Width      = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // stage_q[0] is the newest sample.
  logic [SyncStages-1:0][Width-1:0] stage_q;

  if (SyncStages == 1) begin : g_one
    always_ff @(posedge clk_i) begin
      if (!rst_ni) stage_q <= '0;
      else         stage_q <= d_i;
    end
  end else begin : g_multi
    always_ff @(posedge clk_i) begin
      if (!rst_ni) stage_q <= '0;
      else         stage_q <= {stage_q[SyncStages-2:0], d_i};
    end
  end

  assign q_o = stage_q[SyncStages-1];

endmodule

// File: rtl/cve2_irq_ctrl.sv
// Interrupt front-end: synchronise, level/edge capture with ack-clear, and
// priority-encode the registered pending state into an mcause ID.
module cve2_irq_ctrl
  import cve2_irq_ctrl_pkg::*;
#(
  parameter int unsigned            SyncStages = 2,
  parameter logic [IRQ_NUM_SRC-1:0] EdgeMask   = '0
) (
  input logic            clk_i,
  input logic            rst_ni,
  cve2_irq_ctrl_if.slave irq_if
);

  // Bit IRQ_NUM_SRC of the synchronised vector carries the NMI.
  logic [IRQ_NUM_SRC:0]   s;
  logic [IRQ_NUM_SRC:0]   prev_q;
  logic [IRQ_NUM_SRC:0]   rise;
  logic [IRQ_NUM_SRC-1:0] irq_d, irq_q;
  logic                   nm_clr, nm_d, nm_q;

  cve2_irq_sync #(
    .Width      (IRQ_NUM_SRC + 1),
    .SyncStages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({irq_if.irq_nm_src_i, irq_if.irq_src_i}),
    .q_o    (s)
  );

  assign rise = s & ~prev_q;

  for (genvar i = 0; i < IRQ_NUM_SRC; i++) begin : g_src
    if (EdgeMask[i]) begin : g_edge
      logic clr;
      assign clr      = irq_if.ack_valid_i & (irq_if.ack_id_i == irq_src_id(i));
      // A fresh rise wins over a same-cycle ack so no event is dropped.
      assign irq_d[i] = rise[i] | (irq_q[i] & ~clr);
    end else begin : g_level
      assign irq_d[i] = s[i];
    end
  end

  assign nm_clr = irq_if.ack_valid_i & (irq_if.ack_id_i == IRQ_ID_NM);
  assign nm_d   = rise[IRQ_NUM_SRC] | (nm_q & ~nm_clr);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= '0;
      irq_q  <= '0;
      nm_q   <= 1'b0;
    end else begin
      prev_q <= s;
      irq_q  <= irq_d;
      nm_q   <= nm_d;
    end
  end

  assign irq_if.irqs_o        = irqs_t'(irq_q);
  assign irq_if.irq_nm_o      = nm_q;
  assign irq_if.irq_pending_o = (|irq_q) | nm_q;
  assign irq_if.irq_id_o      = irq_prio_id(irqs_t'(irq_q), nm_q);

endmodule

// File: tb/tb_cve2_irq_ctrl.sv
// Scoreboard bench: the driver queues expected outputs tagged with a cycle, the
// monitor pops and compares them on the falling edge of that cycle.
module tb_cve2_irq_ctrl;
  import cve2_irq_ctrl_pkg::*;

  localparam logic [IRQ_NUM_SRC-1:0] EdgeMask = 18'h0C001;  // ext, fast[14], fast[0]

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cve2_irq_ctrl_if irq_if ();

  cve2_irq_ctrl #(
    .SyncStages (2),
    .EdgeMask   (EdgeMask)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .irq_if (irq_if)
  );

  typedef struct {
    int unsigned at;
    string       name;
    logic [17:0] irqs;
    logic        nm;
    logic [4:0]  id;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [24:0] got, want;
    while (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
      e     = exp_q.pop_front();
      tests = tests + 1;
      got   = {irq_if.irqs_o, irq_if.irq_nm_o, irq_if.irq_pending_o, irq_if.irq_id_o};
      want  = {e.irqs, e.nm, (|e.irqs) | e.nm, e.id};
      if (e.at != cyc) begin
        fails = fails + 1;
        $display("FAIL %s: check slot %0d missed (now cycle %0d)", e.name, e.at, cyc);
      end else if (got !== want) begin
        fails = fails + 1;
        $display("FAIL %s: got irqs=%h nm=%b pend=%b id=%0d, want irqs=%h nm=%b pend=%b id=%0d",
                 e.name, got[24:7], got[6], got[5], got[4:0],
                 want[24:7], want[6], want[5], want[4:0]);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int unsigned d, string name, logic [17:0] irqs, logic nm,
                           logic [4:0] id);
    exp_t e;
    e.at   = cyc + d;
    e.name = name;
    e.irqs = irqs;
    e.nm   = nm;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic ack(logic [4:0] id);
    irq_if.ack_valid_i = 1'b1;
    irq_if.ack_id_i    = id;
    step(1);
    irq_if.ack_valid_i = 1'b0;
    irq_if.ack_id_i    = 5'd0;
  endtask

  initial begin
    rst_n               = 1'b0;
    irq_if.irq_src_i    = '1;
    irq_if.irq_nm_src_i = 1'b1;
    irq_if.ack_valid_i  = 1'b0;
    irq_if.ack_id_i     = 5'd0;
    step(4);
    expect_at(0, "reset_hold", 18'h0, 1'b0, 5'd0);

    // Reset release with only the level timer asserted.
    irq_if.irq_src_i    = 18'h10000;
    irq_if.irq_nm_src_i = 1'b0;
    rst_n               = 1'b1;
    expect_at(2, "reset_release_lat2", 18'h0, 1'b0, 5'd0);
    expect_at(3, "timer_level_lat3", 18'h10000, 1'b0, 5'd7);
    step(3);
    irq_if.irq_src_i = '0;
    expect_at(2, "timer_fall_lat2", 18'h10000, 1'b0, 5'd7);
    expect_at(3, "timer_fall_lat3", 18'h0, 1'b0, 5'd0);
    step(4);

    // Level fast[4]; ack must not affect a level source.
    irq_if.irq_src_i = 18'h00010;
    expect_at(2, "fast4_rise_lat2", 18'h0, 1'b0, 5'd0);
    expect_at(3, "fast4_rise_lat3", 18'h00010, 1'b0, 5'd20);
    step(5);
    expect_at(1, "fast4_ack_ignored", 18'h00010, 1'b0, 5'd20);
    ack(5'd20);
    step(4);
    irq_if.irq_src_i = '0;
    expect_at(2, "fast4_fall_lat2", 18'h00010, 1'b0, 5'd20);
    expect_at(3, "fast4_fall_lat3", 18'h0, 1'b0, 5'd0);
    step(4);

    // Edge external: one-clock pulse latches until acked with id 11.
    irq_if.irq_src_i = 18'h08000;
    step(1);
    irq_if.irq_src_i = '0;
    expect_at(2, "ext_edge_set", 18'h08000, 1'b0, 5'd11);
    expect_at(6, "ext_edge_sticky", 18'h08000, 1'b0, 5'd11);
    step(6);
    expect_at(1, "ext_ack_wrong_id", 18'h08000, 1'b0, 5'd11);
    ack(5'd12);
    expect_at(1, "ext_ack_clear", 18'h0, 1'b0, 5'd0);
    ack(5'd11);
    step(2);

    // Edge fast[0]: new rise in the same cycle as its ack keeps it pending.
    irq_if.irq_src_i = 18'h00001;
    step(1);
    irq_if.irq_src_i = '0;
    expect_at(2, "fast0_set", 18'h00001, 1'b0, 5'd16);
    step(6);
    irq_if.irq_src_i = 18'h00001;
    step(2);
    expect_at(1, "fast0_collision", 18'h00001, 1'b0, 5'd16);
    ack(5'd16);
    expect_at(1, "fast0_second_ack", 18'h0, 1'b0, 5'd0);
    ack(5'd16);
    expect_at(3, "fast0_held_no_rearm", 18'h0, 1'b0, 5'd0);
    step(4);
    irq_if.irq_src_i = '0;
    step(4);

    // Priority walk: sw, timer, fast[14] (edge), fast[2] (level), NMI.
    irq_if.irq_src_i    = 18'h34004;
    irq_if.irq_nm_src_i = 1'b1;
    expect_at(3, "prio_all_nmi", 18'h34004, 1'b1, 5'd31);
    step(3);
    irq_if.irq_nm_src_i = 1'b0;
    expect_at(1, "prio_fast2", 18'h34004, 1'b0, 5'd18);
    ack(5'd31);
    irq_if.irq_src_i = 18'h34000;
    expect_at(3, "prio_fast14", 18'h34000, 1'b0, 5'd30);
    step(3);
    expect_at(1, "prio_software", 18'h30000, 1'b0, 5'd3);
    ack(5'd30);
    irq_if.irq_src_i = 18'h10000;
    expect_at(3, "prio_timer", 18'h10000, 1'b0, 5'd7);
    step(3);
    irq_if.irq_src_i = '0;
    expect_at(3, "prio_none", 18'h0, 1'b0, 5'd0);
    step(4);

    // Held NMI sets once; re-arms only after a low sample.
    irq_if.irq_nm_src_i = 1'b1;
    expect_at(3, "nmi_held_set", 18'h0, 1'b1, 5'd31);
    step(3);
    expect_at(1, "nmi_held_ack", 18'h0, 1'b0, 5'd0);
    ack(5'd31);
    expect_at(46, "nmi_held_no_rearm", 18'h0, 1'b0, 5'd0);
    step(46);
    irq_if.irq_nm_src_i = 1'b0;
    step(4);
    irq_if.irq_nm_src_i = 1'b1;
    expect_at(3, "nmi_rearm", 18'h0, 1'b1, 5'd31);
    step(3);

    // Mid-run reset discards the pending NMI.
    rst_n               = 1'b0;
    irq_if.irq_nm_src_i = 1'b0;
    expect_at(1, "reset_discard", 18'h0, 1'b0, 5'd0);
    step(1);
    rst_n = 1'b1;
    expect_at(4, "reset_discard_after", 18'h0, 1'b0, 5'd0);
    step(6);

    if (exp_q.size() != 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL drain: %0d checks left unserviced, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
